// File: rtl/bcd_add_seq.sv
// Sequential BCD adder: one shared BCD_Add_4 digit cell walks the operands
// LSD first, one digit per clock.
module bcd_add_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                c_in,
    output logic [4*DIGITS-1:0] sum,
    output logic                c_out,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          dbg_state
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);

    // Handshake: start is accepted only in IDLE; busy marks the ADD cycles;
    // done pulses for one cycle in FIN, after which sum/c_out/err are valid and held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_q, b_q;
    logic          carry;
    logic [IW-1:0] idx;
    logic          illegal;
    logic          last;
    logic [3:0]    x_dig, y_dig, z_dig;
    logic          add_co;

    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) illegal = 1'b1;
        end
    end

    assign x_dig = a_q[4*idx +: 4];
    assign y_dig = b_q[4*idx +: 4];
    assign last  = (idx == IW'(DIGITS - 1));

    BCD_Add_4 u_add (
        .c_out (add_co),
        .z     (z_dig),
        .x     (x_dig),
        .y     (y_dig),
        .c_in  (carry)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = illegal ? FIN : ADD;
            ADD:     if (last) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= c_in;
                        idx   <= '0;
                        sum   <= '0;
                        c_out <= 1'b0;
                        err   <= illegal;
                    end
                end
                ADD: begin
                    sum[4*idx +: 4] <= z_dig;
                    carry           <= add_co;
                    idx             <= idx + IW'(1);
                    if (last) c_out <= add_co;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == ADD);
    assign done      = (state == FIN);
    assign dbg_state = state;

endmodule

// Single-digit BCD adder: binary add, then +6 correction when the sum passes 9.
module BCD_Add_4 (
    output logic       c_out,
    output logic [3:0] z,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in
);

    logic [4:0] bin;
    logic [4:0] adj;

    always_comb begin
        bin   = {1'b0, x} + {1'b0, y} + {4'b0, c_in};
        adj   = bin + 5'd6;
        c_out = 1'b0;
        z     = bin[3:0];
        if (bin > 5'd9) begin
            c_out = 1'b1;
            z     = adj[3:0];
        end
    end

endmodule

// File: tb/tb_bcd_add_seq.sv
// Bench for bcd_add_seq: directed cases, mid-op start/reset, back-to-back,
// and random operands against a decimal-arithmetic reference model.
module tb_bcd_add_seq;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         c_in;
    logic [W-1:0] sum;
    logic         c_out, busy, done, err;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;

    bcd_add_seq #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: treat operands as decimal numbers and add them.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                                  output logic [W-1:0] s, output logic co, output logic e);
        int vx = 0;
        int vy = 0;
        int r;
        e = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            int dx = int'(x[4*i +: 4]);
            int dy = int'(y[4*i +: 4]);
            if (dx > 9 || dy > 9) e = 1'b1;
            vx = vx * 10 + dx;
            vy = vy * 10 + dy;
        end
        s  = '0;
        co = 1'b0;
        if (!e) begin
            r  = vx + vy + int'(ci);
            co = (r >= 10 ** DIGITS);
            r  = r % (10 ** DIGITS);
            for (int i = 0; i < DIGITS; i++) begin
                s[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // One full operation with cycle-exact checks; poke pulses start and
    // scrambles operands during ADD cycle 2.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input bit poke);
        logic [W-1:0] es;
        logic         ec, ee;
        model(ta, tb_v, tc, es, ec, ee);
        a = ta; b = tb_v; c_in = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        if (ee) begin
            check("err_done", 32'(done), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
        end else begin
            for (int j = 0; j < DIGITS; j++) begin
                check("add_busy", 32'(busy), 32'd1);
                check("add_done", 32'(done), 32'd0);
                check("add_upper_zero", 32'(sum >> (4 * j)), 32'd0);
                if (poke && j == 1) begin
                    start = 1'b1; a = rand_bcd(); b = rand_bcd();
                end
                if (poke && j == 2) start = 1'b0;
                tick();
            end
            check("fin_done", 32'(done), 32'd1);
            check("fin_busy", 32'(busy), 32'd0);
        end
        check("fin_sum", 32'(sum), 32'(es));
        check("fin_cout", 32'(c_out), 32'(ec));
        check("fin_err", 32'(err), 32'(ee));
        tick();
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("hold_sum", 32'(sum), 32'(es));
        check("hold_cout", 32'(c_out), 32'(ec));
        check("hold_err", 32'(err), 32'(ee));
    endtask

    initial begin
        int last_done;
        int n_done;
        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        run_op(16'h9999, 16'h9999, 1'b1, 1'b0);
        run_op(16'h12A4, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0001, 16'hF000, 1'b1, 1'b0);
        run_op(16'h2468, 16'h1357, 1'b1, 1'b1);

        // Reset dropped between edges during ADD cycle 3.
        a = 16'h4321; b = 16'h1111; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(c_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("in_rst_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        check("after_rst_done", 32'(done), 32'd0);
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0);

        // start held high: done every DIGITS+2 cycles.
        a = 16'h0123; b = 16'h0456; c_in = 1'b0; start = 1'b1;
        last_done = -1;
        n_done = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            if (done) begin
                if (last_done >= 0) check("b2b_gap", 32'(cyc - last_done), 32'(DIGITS + 2));
                check("b2b_sum", 32'(sum), 32'h0579);
                last_done = cyc;
                n_done++;
            end
        end
        check("b2b_count", 32'(n_done), 32'd3);
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("b2b_idle", 32'(busy), 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            ra = rand_bcd();
            rb = rand_bcd();
            if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
            run_op(ra, rb, 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
